ps2_key_controller: RTL and testbench

- Sequences raw PS/2 scan-code bytes from the ps2 receiver into game commands for Snake: direction turns, pause toggle and restart.
- Crosses the receiver's key_pressed strobe from the PS/2 clock domain into the system clock domain.
- Decodes scan-code set 2 prefixes (E0 extended, F0 break).
- Buffers up to two pending turns, which the game core consumes one per game tick.

---
 rtl/ps2_key_controller.sv | 128 ++++++++++++
 tb/tb_ps2_key_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_controller.sv
// ps2_key_controller: turns PS/2 set-2 scan-code bytes into Snake commands
// (queued turns, pause toggle, restart), crossing key_pressed into clk.
module ps2_key_controller #(
   parameter int unsigned PREFIX_TIMEOUT = 2000000,
   parameter logic [1:0]  START_DIR      = 2'b01
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_pressed,
   input  logic [7:0] last_pressed,
   input  logic       tick,
   output logic [1:0] dir,
   output logic       dir_strobe,
   output logic       paused,
   output logic       restart,
   output logic [1:0] queue_count,
   output logic       drop
);
   localparam int CW = $clog2(PREFIX_TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
   state_t state_q, state_d;
   logic [2:0] sync_q;
   logic byte_evt;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0] dir_q, dir_d, q0_q, q0_d, q1_q, q1_d, count_q, count_d;
   logic paused_q, paused_d, dir_strobe_q, dir_strobe_d, restart_q, restart_d, drop_q, drop_d;
   logic is_turn, pause_tog, esc, pop, accept, full;
   logic [1:0] turn_dir, dir_pp, q0_pp, count_pp, ref_dir;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync_q <= '0;
      else sync_q <= {sync_q[1:0], key_pressed};
   assign byte_evt = sync_q[1] & ~sync_q[2];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   // A byte always beats the timeout on the same edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (byte_evt) begin
         cnt_d   = '0;
         state_d = (state_q == IDLE) ? (last_pressed == 8'hF0 ? BRK : last_pressed == 8'hE0 ? EXT : IDLE) :
                   (state_q == EXT && last_pressed == 8'hF0) ? EXT_BRK : IDLE;
      end else if (state_q != IDLE) begin
         state_d = (cnt_q == CW'(PREFIX_TIMEOUT - 1)) ? IDLE : state_q;
         cnt_d   = (cnt_q == CW'(PREFIX_TIMEOUT - 1)) ? '0 : cnt_q + 1'b1;
      end
   end
   always_comb begin
      is_turn   = 1'b0;
      turn_dir  = 2'b00;
      pause_tog = 1'b0;
      esc       = 1'b0;
      if (byte_evt && state_q == IDLE)
         case (last_pressed)
            8'h1D:   {is_turn, turn_dir} = 3'b100;
            8'h23:   {is_turn, turn_dir} = 3'b101;
            8'h1B:   {is_turn, turn_dir} = 3'b110;
            8'h1C:   {is_turn, turn_dir} = 3'b111;
            8'h29:   pause_tog = 1'b1;
            8'h76:   esc = 1'b1;
            default: ;
         endcase
      else if (byte_evt && state_q == EXT)
         case (last_pressed)
            8'h75:   {is_turn, turn_dir} = 3'b100;
            8'h74:   {is_turn, turn_dir} = 3'b101;
            8'h72:   {is_turn, turn_dir} = 3'b110;
            8'h6B:   {is_turn, turn_dir} = 3'b111;
            default: ;
         endcase
   end
   // The pop is applied first so the push sees the post-pop tail.
   assign pop      = tick & ~paused_q & (count_q != 2'd0);
   assign dir_pp   = pop ? q0_q : dir_q;
   assign q0_pp    = pop ? q1_q : q0_q;
   assign count_pp = count_q - {1'b0, pop};
   assign ref_dir  = (count_pp == 2'd0) ? dir_pp : (count_pp == 2'd1) ? q0_pp : q1_q;
   assign accept   = is_turn & ~paused_q & (turn_dir != ref_dir) & ((turn_dir ^ ref_dir) != 2'b10);
   assign full     = count_pp == 2'd2;
   always_comb begin
      dir_d        = dir_pp;
      q0_d         = (accept && count_pp == 2'd0) ? turn_dir : q0_pp;
      q1_d         = (accept && count_pp == 2'd1) ? turn_dir : q1_q;
      count_d      = (accept && !full) ? count_pp + 2'd1 : count_pp;
      paused_d     = paused_q ^ pause_tog;
      dir_strobe_d = pop;
      drop_d       = accept & full;
      restart_d    = esc;
      if (esc) begin
         dir_d        = START_DIR;
         count_d      = 2'd0;
         paused_d     = 1'b0;
         dir_strobe_d = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         dir_q        <= START_DIR;
         q0_q         <= 2'b00;
         q1_q         <= 2'b00;
         count_q      <= 2'd0;
         paused_q     <= 1'b0;
         dir_strobe_q <= 1'b0;
         restart_q    <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         dir_q        <= dir_d;
         q0_q         <= q0_d;
         q1_q         <= q1_d;
         count_q      <= count_d;
         paused_q     <= paused_d;
         dir_strobe_q <= dir_strobe_d;
         restart_q    <= restart_d;
         drop_q       <= drop_d;
      end
   assign dir         = dir_q;
   assign dir_strobe  = dir_strobe_q;
   assign paused      = paused_q;
   assign restart     = restart_q;
   assign queue_count = count_q;
   assign drop        = drop_q;
endmodule

// File: tb/tb_ps2_key_controller.sv
// tb_ps2_key_controller: directed table, corner sequences and a randomized
// run against a queue-based model of the key controller.
module tb_ps2_key_controller;
   localparam int PT = 20;
   localparam logic [1:0] SD = 2'b01;
   typedef struct packed {
      logic [1:0] dir;
      logic [1:0] cnt;
      logic p, ds, rs, dr;
   } outs_t;
   typedef struct packed {
      logic [7:0] b;
      logic nob, tk;
      outs_t e;
   } vec_t;
   logic clk, rst_n, key_pressed, tick, dir_strobe, paused, restart, drop;
   logic [7:0] last_pressed;
   logic [1:0] dir, queue_count;
   int vectors = 0, miscompares = 0, cyc = 0, last_evt = 0;
   logic [1:0] m_dir;
   logic [1:0] m_q[$];
   bit m_paused;
   int m_pend;
   logic [7:0] wasd[4] = '{8'h1D, 8'h23, 8'h1B, 8'h1C};
   logic [7:0] arrows[4] = '{8'h75, 8'h74, 8'h72, 8'h6B};
   logic [7:0] pool[14] = '{8'h1D, 8'h23, 8'h1B, 8'h1C, 8'h75, 8'h74, 8'h72, 8'h6B,
                            8'hE0, 8'hF0, 8'h29, 8'h76, 8'h12, 8'h00};
   vec_t tbl[24];
   ps2_key_controller #(.PREFIX_TIMEOUT(PT), .START_DIR(SD)) dut (
      .clk(clk), .rst_n(rst_n), .key_pressed(key_pressed), .last_pressed(last_pressed),
      .tick(tick), .dir(dir), .dir_strobe(dir_strobe), .paused(paused), .restart(restart),
      .queue_count(queue_count), .drop(drop)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic outs_t o(logic [1:0] d, logic [1:0] c, logic p, logic ds, logic rs, logic dr);
      return {d, c, p, ds, rs, dr};
   endfunction
   function automatic vec_t mk(logic [7:0] b, logic nob, logic tk, outs_t e);
      return {b, nob, tk, e};
   endfunction
   task automatic check(input outs_t e, input string nm);
      outs_t a;
      a = {dir, queue_count, paused, dir_strobe, restart, drop};
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got dir=%b cnt=%0d paused=%b strobe=%b restart=%b drop=%b, expected dir=%b cnt=%0d paused=%b strobe=%b restart=%b drop=%b",
                  nm, a.dir, a.cnt, a.p, a.ds, a.rs, a.dr, e.dir, e.cnt, e.p, e.ds, e.rs, e.dr);
      end
   endtask
   task automatic model_reset();
      m_q.delete();
      m_dir = SD;
      m_paused = 0;
      m_pend = 0;
   endtask
   // m_pend: 0 = no prefix, 1 = after E0, 2 = next byte is a release code
   task automatic model_apply(input bit hb, input logic [7:0] b, input bit tk, output outs_t e);
      bit esc, ptog, is_t;
      logic [1:0] t, r;
      esc = 0; ptog = 0; is_t = 0; t = 2'b00;
      e = '0;
      if (hb) begin
         if (cyc - last_evt > PT) m_pend = 0;
         last_evt = cyc;
         if (m_pend == 0) begin
            esc = b == 8'h76;
            ptog = b == 8'h29;
            for (int i = 0; i < 4; i++) if (b == wasd[i]) begin is_t = 1; t = 2'(i); end
            m_pend = b == 8'hF0 ? 2 : b == 8'hE0 ? 1 : 0;
         end else if (m_pend == 1) begin
            for (int i = 0; i < 4; i++) if (b == arrows[i]) begin is_t = 1; t = 2'(i); end
            m_pend = b == 8'hF0 ? 2 : 0;
         end else m_pend = 0;
      end
      if (esc) begin
         model_reset();
         e.rs = 1;
      end else begin
         if (tk && !m_paused && m_q.size() > 0) begin
            m_dir = m_q.pop_front();
            e.ds = 1;
         end
         if (ptog) m_paused = !m_paused;
         else if (is_t && !m_paused) begin
            r = m_q.size() > 0 ? m_q[$] : m_dir;
            if (t != r && t != (r ^ 2'b10)) begin
               if (m_q.size() < 2) m_q.push_back(t);
               else e.dr = 1;
            end
         end
      end
      e.dir = m_dir;
      e.cnt = 2'(m_q.size());
      e.p = m_paused;
   endtask
   task automatic send(input logic [7:0] b, input bit tk, input bit use_m, input outs_t ein, input string nm);
      outs_t e;
      e = ein;
      key_pressed = 1;
      last_pressed = b;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      tick = tk;
      @(posedge clk); @(negedge clk);
      tick = 0;
      if (use_m) model_apply(1, b, tk, e);
      check(e, nm);
      @(posedge clk); @(negedge clk);
      key_pressed = 0;
      e.ds = 0; e.rs = 0; e.dr = 0;
      check(e, {nm, "_after"});
      repeat (2) begin @(posedge clk); @(negedge clk); end
   endtask
   task automatic tick_op(input bit use_m, input outs_t ein, input string nm);
      outs_t e;
      e = ein;
      tick = 1;
      @(posedge clk); @(negedge clk);
      tick = 0;
      if (use_m) model_apply(0, 8'h00, 1, e);
      check(e, nm);
   endtask
   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); @(negedge clk); end
   endtask
   task automatic do_reset(input string nm);
      @(negedge clk);
      #2 rst_n = 0;
      #1 check(o(SD, 0, 0, 0, 0, 0), nm);
      @(negedge clk);
      rst_n = 1;
   endtask
   initial begin
      rst_n = 0; key_pressed = 0; last_pressed = 8'h00; tick = 0;
      tbl[0]  = mk(8'h1D, 0, 0, o(2'b01, 1, 0, 0, 0, 0));
      tbl[1]  = mk(8'h00, 1, 1, o(2'b00, 0, 0, 1, 0, 0));
      tbl[2]  = mk(8'h76, 0, 0, o(2'b01, 0, 0, 0, 1, 0));
      tbl[3]  = mk(8'hE0, 0, 0, o(2'b01, 0, 0, 0, 0, 0));
      tbl[4]  = mk(8'h72, 0, 0, o(2'b01, 1, 0, 0, 0, 0));
      tbl[5]  = mk(8'hF0, 0, 0, o(2'b01, 1, 0, 0, 0, 0));
      tbl[6]  = mk(8'h1D, 0, 0, o(2'b01, 1, 0, 0, 0, 0));
      tbl[7]  = mk(8'h1C, 0, 0, o(2'b01, 2, 0, 0, 0, 0));
      tbl[8]  = mk(8'h76, 0, 0, o(2'b01, 0, 0, 0, 1, 0));
      tbl[9]  = mk(8'h1C, 0, 0, o(2'b01, 0, 0, 0, 0, 0));
      tbl[10] = mk(8'h1D, 0, 0, o(2'b01, 1, 0, 0, 0, 0));
      tbl[11] = mk(8'h1D, 0, 0, o(2'b01, 1, 0, 0, 0, 0));
      tbl[12] = mk(8'h1C, 0, 0, o(2'b01, 2, 0, 0, 0, 0));
      tbl[13] = mk(8'h1B, 0, 0, o(2'b01, 2, 0, 0, 0, 1));
      tbl[14] = mk(8'h1B, 0, 1, o(2'b00, 2, 0, 1, 0, 0));
      tbl[15] = mk(8'h29, 0, 0, o(2'b00, 2, 1, 0, 0, 0));
      tbl[16] = mk(8'h1D, 0, 0, o(2'b00, 2, 1, 0, 0, 0));
      tbl[17] = mk(8'h00, 1, 1, o(2'b00, 2, 1, 0, 0, 0));
      tbl[18] = mk(8'h29, 0, 0, o(2'b00, 2, 0, 0, 0, 0));
      tbl[19] = mk(8'h76, 0, 1, o(2'b01, 0, 0, 0, 1, 0));
      tbl[20] = mk(8'h29, 0, 0, o(2'b01, 0, 1, 0, 0, 0));
      tbl[21] = mk(8'h1D, 0, 0, o(2'b01, 0, 1, 0, 0, 0));
      tbl[22] = mk(8'h00, 1, 1, o(2'b01, 0, 1, 0, 0, 0));
      tbl[23] = mk(8'h76, 0, 0, o(2'b01, 0, 0, 0, 1, 0));
      #12 check(o(SD, 0, 0, 0, 0, 0), "reset");
      @(negedge clk);
      rst_n = 1;
      key_pressed = 1;
      last_pressed = 8'h1D;
      @(posedge clk); @(negedge clk);
      check(o(SD, 0, 0, 0, 0, 0), "lat_edge1");
      @(posedge clk); @(negedge clk);
      check(o(SD, 0, 0, 0, 0, 0), "lat_edge2");
      @(posedge clk); @(negedge clk);
      check(o(SD, 1, 0, 0, 0, 0), "lat_edge3");
      idle(1);
      key_pressed = 0;
      idle(2);
      do_reset("reset2");
      for (int i = 0; i < 24; i++)
         if (tbl[i].nob) tick_op(0, tbl[i].e, $sformatf("tbl%0d", i));
         else send(tbl[i].b, tbl[i].tk, 0, tbl[i].e, $sformatf("tbl%0d", i));
      send(8'hE0, 0, 0, o(2'b01, 0, 0, 0, 0, 0), "to_e0");
      idle(PT);
      send(8'h75, 0, 0, o(2'b01, 0, 0, 0, 0, 0), "to_75_ignored");
      send(8'hE0, 0, 0, o(2'b01, 0, 0, 0, 0, 0), "edge_e0a");
      idle(PT - 6);
      send(8'h75, 0, 0, o(2'b01, 1, 0, 0, 0, 0), "edge_still_ext");
      send(8'hE0, 0, 0, o(2'b01, 1, 0, 0, 0, 0), "edge_e0b");
      idle(PT - 5);
      send(8'h74, 0, 0, o(2'b01, 1, 0, 0, 0, 0), "edge_timed_out");
      send(8'h29, 0, 0, o(2'b01, 1, 1, 0, 0, 0), "pre_rst_pause");
      send(8'hE0, 0, 0, o(2'b01, 1, 1, 0, 0, 0), "pre_rst_e0");
      do_reset("rst_mid");
      send(8'h75, 0, 0, o(2'b01, 0, 0, 0, 0, 0), "post_rst_75");
      send(8'h1D, 0, 0, o(2'b01, 1, 0, 0, 0, 0), "post_rst_1d");
      do_reset("reset_rand");
      model_reset();
      last_evt = cyc;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) tick_op(1, '0, $sformatf("rnd%0d_tick", i));
         else send(pool[$urandom_range(0, 13)], $urandom_range(0, 2) == 0, 1, '0, $sformatf("rnd%0d", i));
         if ($urandom_range(0, 9) == 0) idle($urandom_range(8, 30));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
